sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single-port map SRAM between two requesters: requester 0 (maze router core) and requester 1 (map loader / dump port driven by the testbench or host).
- Arbitrates fairly with round-robin, and supports locked bursts so the router can run uninterrupted wavefront scans.
- Drives the SRAM pins cs/we/address/data_out and returns read data from data_in to the requester that issued the read.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 8, SRAM address width.
- MAX_BURST, 16, maximum consecutive locked transfers before lock is overridden if the other requester waits; legal 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 access request.
- we0  input  1  requester 0 write (1) / read (0).
- lock0  input  1  requester 0 burst lock.
- addr0  input  ADDR_WIDTH  requester 0 address.
- wdata0  input  DATA_WIDTH  requester 0 write data.
- gnt0  output  1  requester 0 grant (combinational).
- rvalid0  output  1  requester 0 read data valid pulse.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1: same as requester 0, for requester 1.
- rdata  output  DATA_WIDTH  registered read data, shared by both requesters; qualified by rvalidN.
- cs  output  1  SRAM chip select.
- we  output  1  SRAM write enable.
- address  output  ADDR_WIDTH  SRAM address.
- data_out  output  DATA_WIDTH  SRAM write data.
- data_in  input  DATA_WIDTH  SRAM read data, valid the cycle after cs with we=0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low.
- Reset values: cs=0, we=0, address=0, data_out=0, rdata=0, rvalid0=rvalid1=0. Internal state: last=1 (so requester 0 wins the first tie), owner=NONE, burst_cnt=0, read pipeline cleared.
- Handshake:
  - A transfer for requester N occurs at any rising edge where reqN && gntN.
  - The requester holds req/we/addr/wdata stable until that edge.
  - The requester may issue back-to-back transfers every cycle.
- Grant logic (combinational from state and req):
  - If owner=N and reqN: gntN=1, unless burst_cnt==MAX_BURST and the other req is high. In that case the other requester is granted.
  - Else, only one requester active: grant it.
  - Else, both active: grant the requester that is not last.
  - Else: no grant.
  - At most one gnt is high per cycle. No grant is issued without the matching req.
- State machine, owner ∈ {NONE, OWN0, OWN1}, updated on each transfer edge:
  - Transfer by N with lockN=1: owner=OWNN. burst_cnt increments, or resets to 1 if ownership changed.
  - Transfer by N with lockN=0: owner=NONE, burst_cnt=0.
  - last=N on every transfer.
  - No transfer while owner=N and reqN=0: owner is held. The other requester may be granted; this clears owner.
- SRAM drive:
  - On a transfer edge, register cs=1, we=weN, address=addrN, data_out=wdataN.
  - With no transfer: cs=0 and we=0; address and data_out hold their last values.
  - The SRAM sees one access per cycle at most.
- Read return:
  - Read transfer at edge E0 → SRAM samples at E1 → arbiter captures data_in at E2.
  - rdata updates and rvalidN is high for exactly one cycle starting at E2, i.e. 2 edges after the handshake.
  - A 2-deep tag pipeline records requester ID and read flag, so returns stay ordered and correctly steered across grant switches.
  - Writes never produce rvalid.
- Boundary conditions:
  - Address wrap: none; address passes through unmodified.
  - Simultaneous requests with no owner: strict alternation between requesters.
  - MAX_BURST=1: lock is effectively ignored under contention.
  - Reset asserted mid-burst or with reads in flight: all outputs return to reset values immediately, in-flight rvalids are dropped, and ownership is cleared.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined: adds output ports conflict_cnt[15:0] and wait1_max[7:0].
  - conflict_cnt counts cycles with req0 && req1, saturating at 16'hFFFF.
  - wait1_max records the longest run of consecutive cycles req1 was high without gnt1, saturating at 8'hFF.
  - Both reset to 0.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single read: preload SRAM[8'h3C]=8'hA5; req0 read addr 8'h3C → gnt0 the same cycle, cs=1/we=0/address=8'h3C the next cycle, rvalid0=1 with rdata=8'hA5 two edges after the handshake; rvalid1 stays 0.
- Contention: req0 and req1 both held for 6 cycles, no lock, from reset → grants alternate 0,1,0,1,0,1; cs is asserted every cycle.
- Locked burst with MAX_BURST=4: req0 lock0=1 continuously, req1 held → 4 requester-0 transfers, then 1 requester-1 transfer, then requester 0 resumes.
- Write then read across requesters: req1 writes 8'h5A to 8'h10, then req0 reads 8'h10 → rvalid0 with rdata=8'h5A; no rvalid on the write.
- Reset mid-read: assert reset (low) the cycle after a read handshake → cs, we and rvalid go to 0 immediately; after release, no stale rvalid; the next tie goes to requester 0.
- With SRAM_ARB_STATS_EN: 10 cycles of both requesting → conflict_cnt=10; wait1_max=1.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-requester SRAM arbiter with locked bursts
// Optional statistics ports enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cs,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt,
  output logic [7:0]            wait1_max
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_e                owner_q, owner_d;
  logic                  last_q, last_d;
  logic [7:0]            burst_q, burst_d;
  logic                  cs_q, cs_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  p1_rd_q, p1_rd_d, p1_id_q, p1_id_d;
  logic                  p2_rd_q, p2_id_q;
  logic                  rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  at_max, xfer, sel1, sel_lock, sel_we;
  owner_e                new_owner;

  assign at_max = (burst_q == MAX_B);

  // Owner keeps the bus unless its burst budget is spent and the other side waits.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner_q == OWN_0 && req0) begin
      if (at_max && req1) gnt1 = 1'b1;
      else                gnt0 = 1'b1;
    end else if (owner_q == OWN_1 && req1) begin
      if (at_max && req0) gnt0 = 1'b1;
      else                gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (last_q) gnt0 = 1'b1;
      else        gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end
  end

  assign xfer      = gnt0 | gnt1;
  assign sel1      = gnt1;
  assign sel_lock  = sel1 ? lock1 : lock0;
  assign sel_we    = sel1 ? we1 : we0;
  assign new_owner = sel1 ? OWN_1 : OWN_0;

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    p1_rd_d = 1'b0;
    p1_id_d = 1'b0;
    if (xfer) begin
      last_d  = sel1;
      cs_d    = 1'b1;
      we_d    = sel_we;
      addr_d  = sel1 ? addr1 : addr0;
      dout_d  = sel1 ? wdata1 : wdata0;
      p1_rd_d = ~sel_we;
      p1_id_d = sel1;
      if (sel_lock) begin
        owner_d = new_owner;
        // Saturate so an over-long burst stays preemptible.
        if (owner_q == new_owner) burst_d = at_max ? burst_q : burst_q + 8'd1;
        else                      burst_d = 8'd1;
      end else begin
        owner_d = OWN_NONE;
        burst_d = 8'd0;
      end
    end
    rv0_d   = p2_rd_q & ~p2_id_q;
    rv1_d   = p2_rd_q & p2_id_q;
    rdata_d = p2_rd_q ? data_in : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      burst_q <= 8'd0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      p1_rd_q <= 1'b0;
      p1_id_q <= 1'b0;
      p2_rd_q <= 1'b0;
      p2_id_q <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      p1_rd_q <= p1_rd_d;
      p1_id_q <= p1_id_d;
      p2_rd_q <= p1_rd_q;
      p2_id_q <= p1_id_q;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
    end
  end

  assign cs       = cs_q;
  assign we       = we_q;
  assign address  = addr_q;
  assign data_out = dout_q;
  assign rvalid0  = rv0_q;
  assign rvalid1  = rv1_q;
  assign rdata    = rdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conf_q, conf_d;
  logic [7:0]  run_q, run_d, wmax_q, wmax_d;

  always_comb begin
    conf_d = conf_q;
    run_d  = 8'd0;
    wmax_d = wmax_q;
    if (req0 && req1 && conf_q != 16'hFFFF) conf_d = conf_q + 16'd1;
    if (req1 && !gnt1) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    if (run_d > wmax_q) wmax_d = run_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_q <= 16'd0;
      run_q  <= 8'd0;
      wmax_q <= 8'd0;
    end else begin
      conf_q <= conf_d;
      run_q  <= run_d;
      wmax_q <= wmax_d;
    end
  end

  assign conflict_cnt = conf_q;
  assign wait1_max    = wmax_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
// Build with SRAM_ARB_STATS_EN defined to also cover the statistics ports.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata, address, data_out, data_in;
  logic       cs, we;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  wait1_max;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .cs(cs), .we(we), .address(address), .data_out(data_out),
    .data_in(data_in)
`ifdef SRAM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .wait1_max(wait1_max)
`endif
  );

  // One-cycle-latency SRAM model.
  always @(posedge clk) begin
    if (cs) begin
      if (we) mem[address] <= data_out;
      else    data_in <= mem[address];
    end
  end

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 0;
    #2;
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    #3;
    checks++;
    if ({cs, we, rvalid0, rvalid1, gnt0, gnt1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {cs, we, rvalid0, rvalid1, gnt0, gnt1});
    end
    checks++;
    if ({address, data_out, rdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 000000", {address, data_out, rdata});
    end
    tick();
    reset = 1;
  endtask

  task automatic test_single_read();
    tick();
    req0 = 1; we0 = 0; addr0 = 8'h3C;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL read_gnt: got %b want 10", {gnt0, gnt1});
    end
    tick();
    req0 = 0;
    checks++;
    if ({cs, we, address} !== {1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL read_sram: got cs=%b we=%b addr=%h want 1 0 3c", cs, we, address);
    end
    tick();
    checks++;
    if ({cs, rvalid0, rvalid1} !== 3'b000) begin
      errors++;
      $display("FAIL read_e1: got cs/rv0/rv1=%b want 000", {cs, rvalid0, rvalid1});
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'hA5}) begin
      errors++;
      $display("FAIL read_e2: got rv0=%b rv1=%b rdata=%h want 1 0 a5", rvalid0, rvalid1, rdata);
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse: got rvalid0=%b want 0", rvalid0);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'h22;
    for (int i = 0; i < 6; i++) begin
      logic exp1;
      exp1 = (i % 2 == 1);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== {~exp1, exp1}) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {~exp1, exp1});
      end
      tick();
      checks++;
      if ({cs, address} !== {1'b1, exp1 ? 8'h02 : 8'h01}) begin
        errors++;
        $display("FAIL contention_cs[%0d]: got cs=%b addr=%h", i, cs, address);
      end
    end
    idle_inputs();
  endtask

  task automatic test_locked_burst();
    logic exp_who [6];
    exp_who = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulse_reset();
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 8'h20;
    req1 = 1; we1 = 1; lock1 = 0; addr1 = 8'h21;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== {~exp_who[i], exp_who[i]}) begin
        errors++;
        $display("FAIL burst_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {~exp_who[i], exp_who[i]});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    tick();
    req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'h5A;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL wr_gnt: got %b want 01", {gnt0, gnt1});
    end
    tick();
    idle_inputs();
    req0 = 1; we0 = 0; addr0 = 8'h10;
    checks++;
    if ({cs, we, address, data_out} !== {2'b11, 8'h10, 8'h5A}) begin
      errors++;
      $display("FAIL wr_sram: got cs=%b we=%b addr=%h dout=%h want 1 1 10 5a", cs, we, address, data_out);
    end
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rd_gnt: got %b want 10", {gnt0, gnt1});
    end
    tick();
    req0 = 0;
    tick();
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++;
      $display("FAIL wr_no_rvalid: got %b want 00", {rvalid0, rvalid1});
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h5A}) begin
      errors++;
      $display("FAIL wr_rd_data: got rv0=%b rv1=%b rdata=%h want 1 0 5a", rvalid0, rvalid1, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    tick();
    req0 = 1; we0 = 0; addr0 = 8'h3C;
    tick();
    req0 = 0;
    #2;
    reset = 0;
    #1;
    checks++;
    if ({cs, we, rvalid0, rvalid1, address} !== {4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL midrst_out: got cs=%b we=%b rv=%b%b addr=%h want all 0", cs, we, rvalid0, rvalid1, address);
    end
    tick();
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: got %b want 00", i, {rvalid0, rvalid1});
      end
    end
    req0 = 1; we0 = 1; req1 = 1; we1 = 1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_tie: got %b want 10", {gnt0, gnt1});
    end
    tick();
    idle_inputs();
  endtask

`ifdef SRAM_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    req0 = 1; we0 = 1; req1 = 1; we1 = 1;
    repeat (10) tick();
    idle_inputs();
    tick();
    checks++;
    if (conflict_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stats_conflict: got %0d want 10", conflict_cnt);
    end
    checks++;
    if (wait1_max !== 8'd1) begin
      errors++;
      $display("FAIL stats_wait1: got %0d want 1", wait1_max);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h3C] = 8'hA5;
    data_in = 8'h00;
    test_reset();
    test_single_read();
    test_contention();
    test_locked_burst();
    test_write_read();
    test_reset_mid_read();
`ifdef SRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
